// File: rtl/out_port_pkg.sv
// Shared types and constants for the output-port arbiter.
// State encoding, default data width and hold-counter width helper.
package out_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;

  // The counter only has to reach HOLD_CYC-1, but it always needs at least one bit.
  function automatic int hold_cnt_w(input int hold_cyc);
    return (hold_cyc > 1) ? $clog2(hold_cyc) : 1;
  endfunction

endpackage

// File: rtl/out_port_arbiter_rr_pick.sv
// Combinational N_REQ-way round-robin picker: the search starts one past i_ptr and wraps.
// The first active request found becomes the one-hot grant and its index.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_valid
);
  localparam int ID_W = $clog2(N_REQ);

  int              w_cand;
  logic [ID_W-1:0] w_cand_idx;

  always_comb begin
    o_grant    = '0;
    o_idx      = '0;
    o_valid    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand     = (int'(i_ptr) + k) % N_REQ;
      w_cand_idx = ID_W'(w_cand);
      if (!o_valid && i_req[w_cand_idx]) begin
        o_valid             = 1'b1;
        o_idx               = w_cand_idx;
        o_grant[w_cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_port_arbiter.sv
// Arbitrates N_REQ requesters onto one output-port register with a minimum hold time.
// Define OUT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); the default is round-robin.
module out_port_arbiter
  import out_port_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HOLD_CYC = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]          o_ack,
  output logic [DATA_W-1:0]         o_out_port_load,
  output logic                      o_load_en,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id,
  output logic                      o_busy,
  output state_t                    o_dbg_state
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = hold_cnt_w(HOLD_CYC);

  // Handshake: a requester holds i_req (with stable data) until it sees its o_ack pulse,
  // then drops i_req the next cycle. Only requests sampled in IDLE are considered.
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_ptr;
  logic [N_REQ-1:0]   r_ack;
  logic               r_load_en;
  logic [DATA_W-1:0]  r_data;
  logic [ID_W-1:0]    r_gid;

  logic [N_REQ-1:0]   w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_valid;

`ifdef OUT_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest active index is the last one written.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_valid = 1'b1;
        w_idx   = ID_W'(i);
      end
    end
    if (w_valid) w_grant[w_idx] = 1'b1;
  end
`else
  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_valid) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_HOLD;
      ST_HOLD: if (r_cnt == '0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ptr     <= ID_W'(N_REQ - 1);
      r_ack     <= '0;
      r_load_en <= 1'b0;
      r_data    <= '0;
      r_gid     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack     <= '0;
      r_load_en <= 1'b0;
      if (r_state == ST_IDLE && w_valid) begin
        r_ack     <= w_grant;
        r_load_en <= 1'b1;
        r_data    <= i_req_data[int'(w_idx)*DATA_W +: DATA_W];
        r_gid     <= w_idx;
        r_ptr     <= w_idx;
      end
      if (r_state == ST_LOAD) r_cnt <= CNT_W'(HOLD_CYC - 1);
      if (r_state == ST_HOLD && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_ack           = r_ack;
  assign o_load_en       = r_load_en;
  assign o_out_port_load = r_data;
  assign o_grant_id      = r_gid;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_dbg_state     = r_state;

endmodule
